// File: rtl/sat_add_arbiter.sv
// Two-requester round-robin front end sharing one registered symmetric saturating adder.
// Define SAT_ARB_STATS_EN to build the per-requester saturation-event counters.
module sat_add_arbiter #(
  parameter int WIDTH_SUM = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk_80,
  input  logic                        rst_80,
  input  logic                        req_a_valid_80,
  output logic                        req_a_ready_80,
  input  logic signed [WIDTH_SUM-1:0] op_a0_80,
  input  logic signed [WIDTH_SUM-1:0] op_a1_80,
  input  logic                        req_b_valid_80,
  output logic                        req_b_ready_80,
  input  logic signed [WIDTH_SUM-1:0] op_b0_80,
  input  logic signed [WIDTH_SUM-1:0] op_b1_80,
  output logic                        out_valid_80,
  input  logic                        out_ready_80,
  output logic signed [WIDTH_SUM-1:0] out_sum_80,
  output logic                        out_id_80,
  output logic                        out_sat_80,
  input  logic                        sat_cnt_clr_80,
  output logic [CNT_WIDTH-1:0]        sat_cnt_a_80,
  output logic [CNT_WIDTH-1:0]        sat_cnt_b_80
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;
  localparam logic       GRANT_A  = 1'b0;
  localparam logic       GRANT_B  = 1'b1;

  localparam logic signed [WIDTH_SUM-1:0] MIN_CODE = {1'b1, {(WIDTH_SUM-1){1'b0}}};
  localparam logic signed [WIDTH_SUM-1:0] POS_MAX  = ~MIN_CODE;
  localparam logic signed [WIDTH_SUM-1:0] NEG_MAX  = MIN_CODE | {{(WIDTH_SUM-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic                        sat;
    logic signed [WIDTH_SUM-1:0] sum;
  } sat_res_t;

  // Symmetric clamp: the most-negative code never leaves the block, overflow or not.
  function automatic sat_res_t sat_add(input logic signed [WIDTH_SUM-1:0] a,
                                       input logic signed [WIDTH_SUM-1:0] b);
    logic signed [WIDTH_SUM-1:0] s;
    logic                        ovf;
    sat_res_t                    r;
    s     = a + b;
    ovf   = (a[WIDTH_SUM-1] == b[WIDTH_SUM-1]) && (s[WIDTH_SUM-1] != a[WIDTH_SUM-1]);
    r.sat = ovf;
    if (ovf && !a[WIDTH_SUM-1]) begin
      r.sum = POS_MAX;
    end else if (ovf) begin
      r.sum = NEG_MAX;
    end else if (s == MIN_CODE) begin
      r.sum = NEG_MAX;
    end else begin
      r.sum = s;
    end
    return r;
  endfunction

  logic [0:0]                  state_q, state_d;
  logic                        last_grant_q, last_grant_d;
  logic signed [WIDTH_SUM-1:0] sum_q, sum_d;
  logic                        id_q, id_d;
  logic                        sat_q, sat_d;

  logic                        slot_free;
  logic                        xfer_a, xfer_b, xfer;
  logic signed [WIDTH_SUM-1:0] sel_op0, sel_op1;
  sat_res_t                    res;

  always_comb begin
    slot_free      = (state_q == ST_EMPTY) || out_ready_80;
    req_a_ready_80 = !rst_80 && slot_free && (!req_b_valid_80 || (last_grant_q == GRANT_B));
    req_b_ready_80 = !rst_80 && slot_free && (!req_a_valid_80 || (last_grant_q == GRANT_A));
    xfer_a         = req_a_valid_80 && req_a_ready_80;
    xfer_b         = req_b_valid_80 && req_b_ready_80;
    xfer           = xfer_a || xfer_b;
    sel_op0        = xfer_b ? op_b0_80 : op_a0_80;
    sel_op1        = xfer_b ? op_b1_80 : op_a1_80;
    res            = sat_add(sel_op0, sel_op1);
  end

  // A transfer always refills the slot, even when the held result drains on the same edge.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sum_d        = sum_q;
    id_d         = id_q;
    sat_d        = sat_q;
    if (xfer) begin
      state_d      = ST_FULL;
      last_grant_d = xfer_b ? GRANT_B : GRANT_A;
      sum_d        = res.sum;
      id_d         = xfer_b;
      sat_d        = res.sat;
    end else if ((state_q == ST_FULL) && out_ready_80) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_80) begin
    if (rst_80) begin
      state_q      <= ST_EMPTY;
      last_grant_q <= GRANT_B;
      sum_q        <= '0;
      id_q         <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sum_q        <= sum_d;
      id_q         <= id_d;
      sat_q        <= sat_d;
    end
  end

  assign out_valid_80 = (state_q == ST_FULL);
  assign out_sum_80   = sum_q;
  assign out_id_80    = id_q;
  assign out_sat_80   = sat_q;

`ifdef SAT_ARB_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_WIDTH-1:0] cnt_b_q, cnt_b_d;

  // Clear beats increment; counts stick at all-ones.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (sat_cnt_clr_80) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
    end else if (xfer && res.sat) begin
      if (xfer_b) begin
        if (cnt_b_q != '1) cnt_b_d = cnt_b_q + CNT_ONE;
      end else begin
        if (cnt_a_q != '1) cnt_a_d = cnt_a_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_80) begin
    if (rst_80) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign sat_cnt_a_80 = cnt_a_q;
  assign sat_cnt_b_80 = cnt_b_q;
`else
  logic unused_clr;
  assign unused_clr   = sat_cnt_clr_80;
  assign sat_cnt_a_80 = '0;
  assign sat_cnt_b_80 = '0;
`endif

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Self-checking bench for sat_add_arbiter: directed spec vectors plus randomized traffic
// against an integer-arithmetic reference model.
module tb_sat_add_arbiter;
  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_v, a_r, b_v, b_r;
  logic [W-1:0]  a0, a1, b0, b1;
  logic          o_v, o_r, o_id, o_sat;
  logic [W-1:0]  o_sum;
  logic          clr;
  logic [CW-1:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sat_add_arbiter #(.WIDTH_SUM(W), .CNT_WIDTH(CW)) dut (
    .clk_80(clk), .rst_80(rst),
    .req_a_valid_80(a_v), .req_a_ready_80(a_r), .op_a0_80(a0), .op_a1_80(a1),
    .req_b_valid_80(b_v), .req_b_ready_80(b_r), .op_b0_80(b0), .op_b1_80(b1),
    .out_valid_80(o_v), .out_ready_80(o_r), .out_sum_80(o_sum), .out_id_80(o_id),
    .out_sat_80(o_sat), .sat_cnt_clr_80(clr), .sat_cnt_a_80(cnt_a), .sat_cnt_b_80(cnt_b)
  );

  // Reference: true integer sum, clamped to the symmetric range [-max, +max].
  function automatic void ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic sat);
    int ia, ib, s, maxv;
    ia   = int'($signed(a));
    ib   = int'($signed(b));
    maxv = (1 << (W-1)) - 1;
    s    = ia + ib;
    if (s > maxv) begin
      r = W'(maxv); sat = 1'b1;
    end else if (s < -maxv - 1) begin
      r = W'(-maxv); sat = 1'b1;
    end else if (s == -maxv - 1) begin
      r = W'(-maxv); sat = 1'b0;
    end else begin
      r = W'(s); sat = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    a_v = 1'b0; b_v = 1'b0; o_r = 1'b1; clr = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; set_idle();
    a_v = 1'b1; b_v = 1'b1;
    #1;
    checks++;
    if ({a_r, b_r} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got a=%b b=%b, want 0 0", a_r, b_r);
    end
    tick();
    checks++;
    if ({o_v, o_id, o_sat, o_sum} !== '0) begin
      errors++; $display("FAIL reset_out: got v=%b id=%b sat=%b sum=%b, want all 0", o_v, o_id, o_sat, o_sum);
    end
    checks++;
    if (cnt_a !== '0 || cnt_b !== '0) begin
      errors++; $display("FAIL reset_cnt: got a=%0d b=%0d, want 0 0", cnt_a, cnt_b);
    end
    rst = 1'b0; set_idle();
    #1;
    checks++;
    if ({a_r, b_r} !== 2'b11) begin
      errors++; $display("FAIL idle_ready: got a=%b b=%b, want 1 1", a_r, b_r);
    end
  endtask

  task automatic test_directed();
    bit           d_id [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int           d_a  [5] = '{3, 5, -5, -7, -8};
    int           d_b  [5] = '{2, 4, -4, -1, 0};
    logic [W-1:0] d_sum[5] = '{4'b0101, 4'b0111, 4'b1001, 4'b1001, 4'b1001};
    bit           d_sat[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic         rdy;
    set_idle();
    for (int i = 0; i < 5; i++) begin
      if (d_id[i]) begin
        b_v = 1'b1; b0 = W'(d_a[i]); b1 = W'(d_b[i]);
      end else begin
        a_v = 1'b1; a0 = W'(d_a[i]); a1 = W'(d_b[i]);
      end
      #1;
      rdy = d_id[i] ? b_r : a_r;
      checks++;
      if (rdy !== 1'b1) begin
        errors++; $display("FAIL dir_ready[%0d]: got %b, want 1", i, rdy);
      end
      tick();
      a_v = 1'b0; b_v = 1'b0;
      checks++;
      if ({o_v, o_id, o_sat, o_sum} !== {1'b1, d_id[i], d_sat[i], d_sum[i]}) begin
        errors++;
        $display("FAIL dir_out[%0d]: got v=%b id=%b sat=%b sum=%b, want v=1 id=%b sat=%b sum=%b",
                 i, o_v, o_id, o_sat, o_sum, d_id[i], d_sat[i], d_sum[i]);
      end
    end
    tick();
  endtask

  task automatic test_stats();
    logic [CW-1:0] exp_a;
    set_idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (cnt_a !== '0 || cnt_b !== '0) begin
      errors++; $display("FAIL stats_clr0: got a=%0d b=%0d, want 0 0", cnt_a, cnt_b);
    end
    a_v = 1'b1; a0 = W'(5); a1 = W'(4);
    for (int k = 1; k <= 20; k++) begin
      tick();
`ifdef SAT_ARB_STATS_EN
      exp_a = (k > 15) ? CW'(15) : CW'(k);
`else
      exp_a = '0;
`endif
      checks++;
      if (cnt_a !== exp_a || cnt_b !== '0) begin
        errors++; $display("FAIL stats_cnt[%0d]: got a=%0d b=%0d, want a=%0d b=0", k, cnt_a, cnt_b, exp_a);
      end
    end
    clr = 1'b1;
    tick();
    clr = 1'b0; a_v = 1'b0;
    checks++;
    if (cnt_a !== '0 || cnt_b !== '0) begin
      errors++; $display("FAIL stats_clr_prio: got a=%0d b=%0d, want 0 0", cnt_a, cnt_b);
    end
    tick();
  endtask

  task automatic test_alternate();
    logic [W-1:0] es;
    logic         esat;
    logic         exp_b;
    rst = 1'b1; set_idle();
    tick();
    rst = 1'b0;
    a_v = 1'b1; b_v = 1'b1;
    a0 = W'($urandom); a1 = W'($urandom); b0 = W'($urandom); b1 = W'($urandom);
    for (int k = 0; k < 4; k++) begin
      exp_b = k[0];
      #1;
      checks++;
      if ({a_r, b_r} !== {~exp_b, exp_b}) begin
        errors++; $display("FAIL alt_ready[%0d]: got a=%b b=%b, want a=%b b=%b", k, a_r, b_r, ~exp_b, exp_b);
      end
      if (exp_b) ref_sum(b0, b1, es, esat);
      else       ref_sum(a0, a1, es, esat);
      tick();
      checks++;
      if ({o_v, o_id, o_sat, o_sum} !== {1'b1, exp_b, esat, es}) begin
        errors++;
        $display("FAIL alt_out[%0d]: got v=%b id=%b sat=%b sum=%b, want v=1 id=%b sat=%b sum=%b",
                 k, o_v, o_id, o_sat, o_sum, exp_b, esat, es);
      end
      a0 = W'($urandom); a1 = W'($urandom); b0 = W'($urandom); b1 = W'($urandom);
    end
    set_idle();
    tick();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] hs, bs;
    logic         hsat, bsat;
    set_idle();
    tick();
    a_v = 1'b1; a0 = W'($urandom); a1 = W'($urandom);
    ref_sum(a0, a1, hs, hsat);
    tick();
    a_v = 1'b0; o_r = 1'b0;
    b_v = 1'b1; b0 = W'($urandom); b1 = W'($urandom);
    ref_sum(b0, b1, bs, bsat);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({a_r, b_r} !== 2'b00) begin
        errors++; $display("FAIL bp_ready[%0d]: got a=%b b=%b, want 0 0", k, a_r, b_r);
      end
      checks++;
      if ({o_v, o_id, o_sat, o_sum} !== {1'b1, 1'b0, hsat, hs}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%b sat=%b sum=%b, want v=1 id=0 sat=%b sum=%b",
                 k, o_v, o_id, o_sat, o_sum, hsat, hs);
      end
      tick();
    end
    o_r = 1'b1;
    #1;
    checks++;
    if ({a_r, b_r} !== 2'b01) begin
      errors++; $display("FAIL bp_release_ready: got a=%b b=%b, want 0 1", a_r, b_r);
    end
    tick();
    b_v = 1'b0;
    checks++;
    if ({o_v, o_id, o_sat, o_sum} !== {1'b1, 1'b1, bsat, bs}) begin
      errors++;
      $display("FAIL bp_refill: got v=%b id=%b sat=%b sum=%b, want v=1 id=1 sat=%b sum=%b",
               o_v, o_id, o_sat, o_sum, bsat, bs);
    end
    tick();
    checks++;
    if ({o_v, o_id, o_sat, o_sum} !== {1'b0, 1'b1, bsat, bs}) begin
      errors++;
      $display("FAIL bp_drain_hold: got v=%b id=%b sat=%b sum=%b, want v=0 id=1 sat=%b sum=%b",
               o_v, o_id, o_sat, o_sum, bsat, bs);
    end
  endtask

  task automatic test_reset_mid();
    set_idle();
    a_v = 1'b1; a0 = W'(5); a1 = W'(4); o_r = 1'b0;
    tick();
    b_v = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if ({a_r, b_r} !== 2'b00) begin
      errors++; $display("FAIL rstmid_ready: got a=%b b=%b, want 0 0", a_r, b_r);
    end
    tick();
    checks++;
    if ({o_v, o_id, o_sat, o_sum} !== '0) begin
      errors++; $display("FAIL rstmid_out: got v=%b id=%b sat=%b sum=%b, want all 0", o_v, o_id, o_sat, o_sum);
    end
    rst = 1'b0; set_idle();
    tick();
  endtask

  task automatic test_random();
    bit           m_full, m_last, m_id, m_sat;
    logic [W-1:0] m_sum, rs;
    logic         rsat;
    int           m_ca, m_cb;
    bit           free, era, erb, xa, xb;
    int           maxc;
    maxc = (1 << CW) - 1;
    rst = 1'b1; set_idle();
    tick();
    rst = 1'b0;
    m_full = 1'b0; m_last = 1'b1; m_id = 1'b0; m_sat = 1'b0; m_sum = '0; m_ca = 0; m_cb = 0;
    for (int i = 0; i < 600; i++) begin
      checks++;
      if ({o_v, o_id, o_sat, o_sum} !== {m_full, m_id, m_sat, m_sum}) begin
        errors++;
        $display("FAIL rand_out[%0d]: got v=%b id=%b sat=%b sum=%b, want v=%b id=%b sat=%b sum=%b",
                 i, o_v, o_id, o_sat, o_sum, m_full, m_id, m_sat, m_sum);
      end
      checks++;
      if (cnt_a !== CW'(m_ca) || cnt_b !== CW'(m_cb)) begin
        errors++; $display("FAIL rand_cnt[%0d]: got a=%0d b=%0d, want a=%0d b=%0d", i, cnt_a, cnt_b, m_ca, m_cb);
      end
      a_v = ($urandom_range(0, 3) != 0);
      b_v = ($urandom_range(0, 3) != 0);
      o_r = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      a0 = W'($urandom); a1 = W'($urandom); b0 = W'($urandom); b1 = W'($urandom);
      #1;
      free = !m_full || o_r;
      era  = free && (!b_v || m_last);
      erb  = free && (!a_v || !m_last);
      checks++;
      if ({a_r, b_r} !== {era, erb}) begin
        errors++; $display("FAIL rand_ready[%0d]: got a=%b b=%b, want a=%b b=%b", i, a_r, b_r, era, erb);
      end
      xa = a_v && era;
      xb = b_v && erb;
      if (xa || xb) begin
        if (xb) ref_sum(b0, b1, rs, rsat);
        else    ref_sum(a0, a1, rs, rsat);
        m_full = 1'b1; m_last = xb; m_id = xb; m_sum = rs; m_sat = rsat;
`ifdef SAT_ARB_STATS_EN
        if (rsat) begin
          if (xb) m_cb = (m_cb < maxc) ? m_cb + 1 : m_cb;
          else    m_ca = (m_ca < maxc) ? m_ca + 1 : m_ca;
        end
`endif
      end else if (m_full && o_r) begin
        m_full = 1'b0;
      end
`ifdef SAT_ARB_STATS_EN
      if (clr) begin
        m_ca = 0; m_cb = 0;
      end
`endif
      tick();
    end
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    set_idle();
    tick();
    test_reset();
    test_directed();
    test_stats();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
